// File: rtl/uart_tx_slave.sv
// rtl/uart_tx_slave.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Stores to the TXDATA register are queued in a TX FIFO. A serialiser then drains
// the FIFO and sends each byte 8N1, LSB first, on tx.
//
// Ports:
//   clk, rst           system clock; synchronous active-high reset
//   address[1:0]       word offset (0 TXDATA, 1 STATUS, 2 BAUD, 3 reserved)
//   we, mem_read       write / read strobes
//   mask_byte[3:0]     byte enables (only bit 0 matters, for TXDATA)
//   write_data[31:0]   store data
//   read_data[31:0]    combinational load data, 0 when mem_read=0
//   tx                 serial line, idle high
//   tx_empty           FIFO empty and serialiser idle
module uart_tx_slave #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  address,
  input  logic        we,
  input  logic        mem_read,
  input  logic [3:0]  mask_byte,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        tx_empty
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     baud_q, baud_d;
  logic [15:0]     bit_div_q, bit_div_d;
  logic [15:0]     baud_cnt_q, baud_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_idx_q, bit_idx_d;

  logic empty, full, busy, pop, push_req, push, cnt_done;
  logic unused_bits;

  assign unused_bits = ^{mask_byte[3:1], write_data[31:16]};

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign busy     = (state_q != S_IDLE);
  assign pop      = (state_q == S_IDLE) && !empty;
  assign push_req = we && (address == 2'd0) && mask_byte[0];
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign cnt_done = (baud_cnt_q == 16'd0);
  assign tx_empty = empty && !busy;

  // FIFO bookkeeping and register writes
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
    // Setting on a dropped byte wins over a simultaneous clear.
    overflow_d = (push_req && !push) ||
                 (overflow_q && !(we && address == 2'd1 && write_data[3]));
    baud_d = baud_q;
    if (we && address == 2'd2)
      baud_d = (write_data[15:0] == 16'd0) ? 16'd1 : write_data[15:0];
  end

  // Serialiser next state
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_div_d  = bit_div_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = cnt_done ? bit_div_q - 16'd1 : baud_cnt_q - 16'd1;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = baud_cnt_q;
        if (!empty) begin
          // bit_div is frozen per frame so BAUD writes only affect later frames.
          shift_d    = mem[rd_ptr_q];
          bit_div_d  = baud_q;
          baud_cnt_d = baud_q - 16'd1;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (cnt_done) begin
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Serialiser output
  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  always_comb begin
    read_data = 32'd0;
    if (mem_read) begin
      case (address)
        2'd1:    read_data = {28'd0, overflow_q, busy, full, empty};
        2'd2:    read_data = {16'd0, baud_q};
        default: read_data = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      baud_q     <= DEFAULT_DIV;
      bit_div_q  <= DEFAULT_DIV;
      baud_cnt_q <= 16'd0;
      shift_q    <= 8'd0;
      bit_idx_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      baud_q     <= baud_d;
      bit_div_q  <= bit_div_d;
      baud_cnt_q <= baud_cnt_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

endmodule
